// File: rtl/spi_eeprom_slave.sv
// SPI mode-0 EEPROM-style slave with byte memory, WREN/WRDI/RDSR/READ/WRITE.
// All SPI pins are resynchronised into ACLK; SCK must be slow (>=4 ACLK per half).
module spi_eeprom_slave #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  INIT_BYTE = 8'hFF
) (
    input  logic ACLK,
    input  logic RST,
    input  logic SPI_SCK,
    input  logic SPI_CS,
    input  logic SPI_MOSI,
    output logic SPI_MISO,
    output logic SPI_MISO_OE,
    output logic WEL
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_ADDR_H  = 3'd2;
    localparam logic [2:0] S_ADDR_L  = 3'd3;
    localparam logic [2:0] S_WR_DATA = 3'd4;
    localparam logic [2:0] S_RD_DATA = 3'd5;
    localparam logic [2:0] S_RDSR    = 3'd6;
    localparam logic [2:0] S_IGNORE  = 3'd7;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    logic [1:0]        sck_s;
    logic [1:0]        cs_s;
    logic [1:0]        mosi_s;
    logic              sck_q;
    logic              cs_q;
    logic [1:0]        vld;
    logic              armed;

    logic [2:0]        state;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_sh;
    logic [7:0]        tx_sh;
    logic [7:0]        addr_h;
    logic [ADDR_W-1:0] addr;
    logic              wel_q;
    logic              is_read;
    logic              wr_ok;
    logic              wrote;
    logic              load_pend;

    logic [7:0]        mem [DEPTH];

    logic              sck_rise;
    logic              sck_fall;
    logic              cs_low;
    logic              cs_fall;
    logic              cs_rise;
    logic              active;
    logic              bit_in;
    logic              byte_done;
    logic [7:0]        rx_byte;
    logic [15:0]       addr_full;
    logic              mem_we;
    logic              rd_phase;

    // Two-flop synchronisers plus one delay flop for edge detection;
    // armed blocks decoding until CS has been seen high after reset.
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            sck_s  <= 2'b00;
            cs_s   <= 2'b11;
            mosi_s <= 2'b00;
            sck_q  <= 1'b0;
            cs_q   <= 1'b1;
            vld    <= 2'b00;
            armed  <= 1'b0;
        end else begin
            sck_s  <= {sck_s[0], SPI_SCK};
            cs_s   <= {cs_s[0], SPI_CS};
            mosi_s <= {mosi_s[0], SPI_MOSI};
            sck_q  <= sck_s[1];
            cs_q   <= cs_s[1];
            vld    <= {vld[0], 1'b1};
            if (vld[1] && cs_s[1])
                armed <= 1'b1;
        end
    end

    // Edge strobes and per-bit / per-byte qualifiers.
    always_comb begin
        sck_rise  = sck_s[1] & ~sck_q;
        sck_fall  = ~sck_s[1] & sck_q;
        cs_low    = ~cs_s[1];
        cs_fall   = armed & cs_low & cs_q;
        cs_rise   = cs_s[1] & ~cs_q;
        active    = cs_low && (state != S_IDLE);
        bit_in    = active && sck_rise;
        rx_byte   = {rx_sh[6:0], mosi_s[1]};
        byte_done = bit_in && (bit_cnt == 3'd7);
        addr_full = {addr_h, rx_byte};
        mem_we    = byte_done && (state == S_WR_DATA) && wr_ok;
        rd_phase  = (state == S_RD_DATA) || (state == S_RDSR);
    end

    // Transaction FSM, shift registers, address and write-enable latch.
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            rx_sh     <= 8'h00;
            tx_sh     <= 8'h00;
            addr_h    <= 8'h00;
            addr      <= '0;
            wel_q     <= 1'b0;
            is_read   <= 1'b0;
            wr_ok     <= 1'b0;
            wrote     <= 1'b0;
            load_pend <= 1'b0;
        end else if (cs_rise) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            rx_sh     <= 8'h00;
            tx_sh     <= 8'h00;
            load_pend <= 1'b0;
            wr_ok     <= 1'b0;
            wrote     <= 1'b0;
            if (wrote)
                wel_q <= 1'b0;
        end else if (cs_fall) begin
            state     <= S_CMD;
            bit_cnt   <= 3'd0;
            rx_sh     <= 8'h00;
            tx_sh     <= 8'h00;
            load_pend <= 1'b0;
            wr_ok     <= 1'b0;
            wrote     <= 1'b0;
        end else begin
            if (bit_in) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sh   <= rx_byte;
            end
            if (byte_done) begin
                case (state)
                    S_CMD: begin
                        case (rx_byte)
                            OP_WREN: begin
                                wel_q <= 1'b1;
                                state <= S_IGNORE;
                            end
                            OP_WRDI: begin
                                wel_q <= 1'b0;
                                state <= S_IGNORE;
                            end
                            OP_RDSR: begin
                                load_pend <= 1'b1;
                                state     <= S_RDSR;
                            end
                            OP_READ: begin
                                is_read <= 1'b1;
                                state   <= S_ADDR_H;
                            end
                            OP_WRITE: begin
                                is_read <= 1'b0;
                                wr_ok   <= wel_q;
                                state   <= S_ADDR_H;
                            end
                            default: state <= S_IGNORE;
                        endcase
                    end
                    S_ADDR_H: begin
                        addr_h <= rx_byte;
                        state  <= S_ADDR_L;
                    end
                    S_ADDR_L: begin
                        addr      <= addr_full[ADDR_W-1:0];
                        load_pend <= is_read;
                        state     <= is_read ? S_RD_DATA : S_WR_DATA;
                    end
                    S_WR_DATA: begin
                        addr <= addr + ADDR_W'(1);
                        if (wr_ok)
                            wrote <= 1'b1;
                    end
                    S_RD_DATA: begin
                        addr      <= addr + ADDR_W'(1);
                        load_pend <= 1'b1;
                    end
                    S_RDSR: load_pend <= 1'b1;
                    default: ;
                endcase
            end
            if (active && sck_fall && rd_phase) begin
                if (load_pend) begin
                    load_pend <= 1'b0;
                    if (state == S_RD_DATA)
                        tx_sh <= mem[addr];
                    else
                        tx_sh <= {6'b0, wel_q, 1'b0};
                end else begin
                    tx_sh <= {tx_sh[6:0], 1'b0};
                end
            end
        end
    end

    // Byte memory, cleared to INIT_BYTE by reset.
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= INIT_BYTE;
        end else if (mem_we) begin
            mem[addr] <= rx_byte;
        end
    end

    // Outputs: drive MISO only while a read phase owns the bus.
    always_comb begin
        SPI_MISO_OE = rd_phase && cs_low;
        SPI_MISO    = SPI_MISO_OE & tx_sh[7];
        WEL         = wel_q;
    end

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// Directed bench for spi_eeprom_slave: SCK = ACLK/16, mode 0 master model.
// Expected values are hand-derived from the command sequences below.
module tb_spi_eeprom_slave;

    localparam time HP = 80;

    logic ACLK = 1'b0;
    logic RST = 1'b1;
    logic SPI_SCK = 1'b0;
    logic SPI_CS = 1'b1;
    logic SPI_MOSI = 1'b0;
    logic SPI_MISO;
    logic SPI_MISO_OE;
    logic WEL;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx;
    logic       oe;

    always #5 ACLK = ~ACLK;

    spi_eeprom_slave #(.ADDR_W(8), .INIT_BYTE(8'hFF)) dut (
        .ACLK(ACLK),
        .RST(RST),
        .SPI_SCK(SPI_SCK),
        .SPI_CS(SPI_CS),
        .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO),
        .SPI_MISO_OE(SPI_MISO_OE),
        .WEL(WEL)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] r, output logic o);
        r = 8'h00;
        o = 1'b1;
        for (int i = 7; i >= 8 - nbits; i--) begin
            SPI_MOSI = tx[i];
            #HP;
            r[i] = SPI_MISO;
            o = o & SPI_MISO_OE;
            SPI_SCK = 1'b1;
            #HP;
            SPI_SCK = 1'b0;
        end
    endtask

    task automatic sel();
        SPI_CS = 1'b0;
        #HP;
    endtask

    task automatic desel();
        #HP;
        SPI_CS = 1'b1;
        SPI_MOSI = 1'b0;
        #(2 * HP);
    endtask

    task automatic put(input logic [7:0] b);
        logic [7:0] r;
        logic o;
        xfer(b, 8, r, o);
    endtask

    task automatic op1(input logic [7:0] b);
        sel();
        put(b);
        desel();
    endtask

    initial begin
        #30;
        chk("rst_miso", {7'b0, SPI_MISO}, 8'h00);
        chk("rst_oe", {7'b0, SPI_MISO_OE}, 8'h00);
        chk("rst_wel", {7'b0, WEL}, 8'h00);
        RST = 1'b0;
        #100;

        // WREN, WRITE 00 F0 AA, READ back
        op1(8'h06);
        chk("wren_wel", {7'b0, WEL}, 8'h01);
        sel(); put(8'h02); put(8'h00); put(8'hF0); put(8'hAA); desel();
        chk("wel_after_write", {7'b0, WEL}, 8'h00);
        sel(); put(8'h03); put(8'h00);
        xfer(8'hF0, 8, rx, oe);
        chk("oe_addr_byte", {7'b0, oe}, 8'h00);
        xfer(8'h00, 8, rx, oe);
        chk("read_f0", rx, 8'hAA);
        chk("oe_read_data", {7'b0, oe}, 8'h01);
        desel();
        chk("oe_after_cs", {7'b0, SPI_MISO_OE}, 8'h00);
        chk("miso_after_cs", {7'b0, SPI_MISO}, 8'h00);

        // WREN then RDSR twice; WRDI then RDSR
        op1(8'h06);
        sel(); put(8'h05);
        xfer(8'h00, 8, rx, oe);
        chk("rdsr_1", rx, 8'h02);
        xfer(8'h00, 8, rx, oe);
        chk("rdsr_2", rx, 8'h02);
        desel();
        op1(8'h04);
        chk("wrdi_wel", {7'b0, WEL}, 8'h00);
        sel(); put(8'h05);
        xfer(8'h00, 8, rx, oe);
        chk("rdsr_wrdi", rx, 8'h00);
        desel();

        // WRITE without WREN is dropped
        sel(); put(8'h02); put(8'h00); put(8'h10); put(8'h55); desel();
        sel(); put(8'h03); put(8'h00); put(8'h10);
        xfer(8'h00, 8, rx, oe);
        chk("nowel_read_10", rx, 8'hFF);
        desel();

        // Write across the top address, read wraps to 0x00
        op1(8'h06);
        sel(); put(8'h02); put(8'h00); put(8'hFF);
        put(8'h11); put(8'h22); desel();
        chk("wel_after_wrap", {7'b0, WEL}, 8'h00);
        sel(); put(8'h03); put(8'h00); put(8'hFF);
        xfer(8'h00, 8, rx, oe);
        chk("wrap_read_ff", rx, 8'h11);
        xfer(8'h00, 8, rx, oe);
        chk("wrap_read_00", rx, 8'h22);
        desel();

        // Partial data byte is discarded
        op1(8'h06);
        sel(); put(8'h02); put(8'h00); put(8'h20);
        xfer(8'h3C, 5, rx, oe);
        desel();
        chk("partial_wel", {7'b0, WEL}, 8'h01);
        sel(); put(8'h03); put(8'h00); put(8'h20);
        xfer(8'h00, 8, rx, oe);
        chk("partial_read_20", rx, 8'hFF);
        desel();

        // Reset pulse during an address byte
        op1(8'h06);
        sel(); put(8'h03); put(8'h00); put(8'hF0);
        xfer(8'h00, 3, rx, oe);
        chk("pre_rst_oe", {7'b0, SPI_MISO_OE}, 8'h01);
        desel();
        sel(); put(8'h02);
        xfer(8'h00, 4, rx, oe);
        RST = 1'b1;
        #1;
        chk("midrst_miso", {7'b0, SPI_MISO}, 8'h00);
        chk("midrst_oe", {7'b0, SPI_MISO_OE}, 8'h00);
        chk("midrst_wel", {7'b0, WEL}, 8'h00);
        #19;
        RST = 1'b0;
        #100;
        put(8'h06);
        desel();
        chk("no_fresh_cs_wel", {7'b0, WEL}, 8'h00);
        op1(8'h06);
        chk("post_rst_wren", {7'b0, WEL}, 8'h01);
        sel(); put(8'h02); put(8'h00); put(8'h30); put(8'h5A); desel();
        chk("post_rst_wel", {7'b0, WEL}, 8'h00);
        sel(); put(8'h03); put(8'h00); put(8'h30);
        xfer(8'h00, 8, rx, oe);
        chk("post_rst_read_30", rx, 8'h5A);
        xfer(8'h00, 8, rx, oe);
        chk("post_rst_read_31", rx, 8'hFF);
        desel();
        sel(); put(8'h03); put(8'h00); put(8'hF0);
        xfer(8'h00, 8, rx, oe);
        chk("post_rst_mem_f0", rx, 8'hFF);
        desel();

        // Unknown opcode leaves WEL untouched and never drives MISO
        op1(8'h06);
        sel(); put(8'hA5);
        xfer(8'hFF, 8, rx, oe);
        chk("ignore_oe", {7'b0, oe}, 8'h00);
        desel();
        chk("ignore_wel", {7'b0, WEL}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_eeprom_slave.md
SPI_EEPROM_SLAVE -- requirements
Module: spi_eeprom_slave

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width; depth is 2**ADDR_W bytes.
REQ-002 Parameter INIT_BYTE, default 8'hFF, value of every memory location after reset.
REQ-003 ACLK  input  1  system clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 SPI_SCK  input  1  SPI clock from the master, mode 0 only (CPOL=0, CPHA=0), asynchronous to ACLK.
REQ-006 SPI_CS  input  1  chip select, active low.
REQ-007 SPI_MOSI  input  1  serial data in, MSB first.
REQ-008 SPI_MISO  output  1  serial data out, MSB first.
REQ-009 SPI_MISO_OE  output  1  high while the slave drives SPI_MISO in a read phase.
REQ-010 WEL  output  1  write-enable latch, mirrors status bit 1.

Function
REQ-011 SPI_SCK, SPI_CS and SPI_MOSI SHALL pass through 2-flop synchronizers; edges are detected on the synchronized signals; SCK half-period SHALL be at least 4 ACLK cycles (a bench using ACLK/16 complies).
REQ-012 MOSI SHALL be sampled on each synchronized SCK rising edge while CS is low; MISO SHALL change only on synchronized SCK falling edges, 3 ACLK cycles or fewer after the pin edge.
REQ-013 A 3-bit bit counter SHALL complete a byte on every 8th rising edge; CS rising or falling SHALL clear it.
REQ-014 States: IDLE, CMD, ADDR_H, ADDR_L, WR_DATA, RD_DATA, RDSR, IGNORE; CS falling SHALL move IDLE->CMD; CS rising SHALL return any state to IDLE.
REQ-015 CMD opcode decode: 8'h06 WREN sets WEL, then IGNORE; 8'h04 WRDI clears WEL, then IGNORE; 8'h05 RDSR -> RDSR; 8'h03 READ -> ADDR_H; 8'h02 WRITE -> ADDR_H; any other opcode -> IGNORE.
REQ-016 ADDR_H then ADDR_L each take one byte; the address is the 16-bit value {ADDR_H, ADDR_L} truncated to its low ADDR_W bits; ADDR_L SHALL move to RD_DATA or WR_DATA according to the latched opcode.
REQ-017 WR_DATA: each completed byte SHALL be written to memory at the current address in the same ACLK cycle, only if WEL was 1 when the WRITE opcode completed; then address increments modulo 2**ADDR_W.
REQ-018 A WRITE transaction with WEL=1 SHALL clear WEL on CS rising if at least one data byte was written; WREN/WRDI take effect at opcode completion, even if CS stays low.
REQ-019 RD_DATA: on the SCK falling edge after ADDR_L completes, the byte at the address SHALL be loaded into the shift register with bit 7 on SPI_MISO; after each further 8 bits the address increments modulo 2**ADDR_W and the next byte loads on that falling edge.
REQ-020 RDSR: shift out {6'b0, WEL, 1'b0} repeatedly (WIP always 0), loaded the same way as REQ-019.
REQ-021 SPI_MISO_OE SHALL be 1 only in RD_DATA and RDSR with CS low; otherwise SPI_MISO SHALL be 0 and OE 0.
REQ-022 A partial byte at CS rising SHALL be discarded with no memory write and no WEL change.
REQ-023 MOSI bits in IGNORE, RD_DATA and RDSR SHALL be ignored.

Reset
REQ-024 RST SHALL asynchronously force state IDLE, bit counter 0, shift registers 0, address 0, WEL=0, SPI_MISO=0, SPI_MISO_OE=0, synchronizers to SCK=0/CS=1/MOSI=0, all memory to INIT_BYTE.
REQ-025 RST asserted mid-transaction SHALL abort it; after release the block SHALL wait for a fresh CS falling edge before decoding.

Verification
REQ-026 CS low, 06, CS high; CS low, 02 00 F0 AA, CS high; CS low, 03 00 F0 plus 8 clocks -> MISO returns 8'hAA, OE=1 during data, WEL=0 after write.
REQ-027 WREN then RDSR with 16 clocks -> 8'h02 twice; WRDI then RDSR -> 8'h00.
REQ-028 WRITE 00 10 55 without a prior WREN, then READ 00 10 -> 8'hFF (INIT_BYTE), memory unchanged.
REQ-029 WREN; WRITE 00 FF 11 22; READ 00 FF plus 16 clocks -> 8'h11 then 8'h22 (read from address 0x00, wrap).
REQ-030 WREN; WRITE 00 20, 5 data bits then CS high -> no write and WEL stays 1; read at 0x20 -> 8'hFF.
REQ-031 RST pulse during an address byte -> outputs 0 at once, WEL=0, the next full WREN/WRITE/READ sequence works normally.
